wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Schedules all register-file writebacks onto the dual-write-port register file (port 1: Write/WR/WD; port 2: Write2/WR2/WD2).
- Two in-order pipeline lanes write with zero latency and fixed precedence.
- Results from the long-latency unit (LLU, mul/div) are buffered in a small FIFO and drained into write ports the lanes leave free.
- Keeps write-after-write ordering correct and exports a pending-write busy vector to the hazard logic.

Parameters:
- DEPTH, 4, LLU result FIFO entries; power of 2, >= 2.
- STARVE_LIMIT, 8, cycles the FIFO head may wait before the lanes are stalled.
- AGE_W, 4, width of the head age counter; must hold STARVE_LIMIT.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- a_valid  in  1  lane A (older slot) writeback valid
- a_wr  in  5  lane A destination register
- a_wd  in  32  lane A data
- b_valid  in  1  lane B (younger slot) writeback valid
- b_wr  in  5  lane B destination register
- b_wd  in  32  lane B data
- llu_valid  in  1  LLU result valid
- llu_wr  in  5  LLU destination register
- llu_wd  in  32  LLU data
- llu_ready  out  1  FIFO can accept an LLU result
- Write  out  1  port 1 write enable (older write)
- WR  out  5  port 1 address
- WD  out  32  port 1 data
- Write2  out  1  port 2 write enable (younger write; wins on equal address)
- WR2  out  5  port 2 address
- WD2  out  32  port 2 data
- stall_o  out  1  pipeline must hold; lane valids are ignored while high
- busy_o  out  32  bit r set while a live FIFO entry targets register r

Behaviour:
- Reset:
  - FIFO empty; all kill bits and the age counter cleared.
  - Write=Write2=0; stall_o=0; busy_o=0; llu_ready=0 while Reset is high, then 1.
- Lane writes ("lane_ok" = lane valid and stall_o=0):
  - Both lanes ok: A->port 1, B->port 2, same cycle; FIFO does not drain.
  - One lane ok: that lane->port 2; FIFO head (if live) may use port 1.
  - No lane ok: FIFO head->port 1 and head+1->port 2. Head+1 uses port 2 only if the head was also popped this cycle.
- Write-port outputs are combinational from FIFO state and lane inputs. The register file samples them at the next Clk edge.
- LLU acceptance:
  - Accepted on llu_valid && llu_ready; llu_ready = (count < DEPTH).
  - llu_wr=0: accepted and discarded, never enqueued.
  - Earliest write of an accepted entry is the following cycle (bypass: see Optional Feature).
- Kill (WAW):
  - Any lane_ok write to register r marks every FIFO entry with wr=r as killed. This includes an LLU entry accepted that same cycle, because LLU results are always older than the current lane writes.
  - Killed entries pop without using a port. Up to 2 pops per cycle, in head order, live or killed.
  - A live entry that finds no free port blocks later entries. There is no reordering.
- busy_o: OR over live, not-killed entries of their wr decode, computed from registered state.
- Age / stall:
  - The age counter resets to 0 when the head pops or the FIFO is empty; otherwise it increments, saturating.
  - stall_o = (age >= STARVE_LIMIT) || (count >= DEPTH-1). It is a function of registers only.
- Boundaries:
  - Full FIFO: llu_ready=0 and the LLU holds its data.
  - Simultaneous pop and push when full: push is not allowed (llu_ready comes from registered count).
  - Pointers wrap modulo DEPTH.
  - Reset mid-operation: all queued entries are discarded.

Optional Feature:
- Macro WBARB_BYPASS_EN.
- Defined: when the FIFO is empty, llu_valid=1, and port 1 is free this cycle, the LLU result writes through port 1 in the same cycle and is not enqueued.
- Not defined: all LLU results pass through the FIFO (minimum one cycle latency).

Test Plan:
- Lanes only: A(r3,0x11), B(r3,0x22) -> Write/WR=3/WD=0x11 and Write2/WR2=3/WD2=0x22 the same cycle; r3 ends as 0x22.
- LLU drain: LLU r5=0xAA accepted with lanes idle -> next cycle Write=1, WR=5, WD=0xAA; busy_o[5] high for exactly that one cycle.
- Kill: LLU r7 queued while lanes busy, then lane A writes r7=0x1 -> entry popped with no write; r7 stays 0x1; busy_o[7] clears.
- Starvation: 4 LLU results queued (DEPTH=4), both lanes valid every cycle -> stall_o=1 at count>=3; FIFO then drains 2 per cycle; stall_o drops.
- Full: DEPTH entries queued -> llu_ready=0; LLU holds; one pop -> llu_ready=1 the next cycle.
- Reset with 3 queued entries -> no writes after reset; busy_o=0; llu_ready=1 one cycle after Reset falls.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two in-order lanes plus a queued long-latency unit onto a 2-write-port regfile.
// Optional same-cycle LLU write-through when the FIFO is empty: define WBARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned AGE_W        = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        a_valid,
    input  logic [4:0]  a_wr,
    input  logic [31:0] a_wd,
    input  logic        b_valid,
    input  logic [4:0]  b_wr,
    input  logic [31:0] b_wd,
    input  logic        llu_valid,
    input  logic [4:0]  llu_wr,
    input  logic [31:0] llu_wd,
    output logic        llu_ready,
    output logic        Write,
    output logic [4:0]  WR,
    output logic [31:0] WD,
    output logic        Write2,
    output logic [4:0]  WR2,
    output logic [31:0] WD2,
    output logic        stall_o,
    output logic [31:0] busy_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_HIGH  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]    CNT_TWO   = CW'(2);
    localparam logic [AGE_W-1:0] AGE_LIM   = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_MAX   = '1;

    logic [4:0]       wr_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] kill_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [AGE_W-1:0] age;
    logic             ready_en;

    logic          a_ok, b_ok, p1_free, p2_free;
    logic [PW-1:0] h0, h1;
    logic          kill0, kill1;
    logic          pop0, pop1, p1_used, bypass, push;
    logic [1:0]    npop;

    function automatic logic lane_hit(input logic [4:0] r, input logic ao, input logic [4:0] aw,
                                      input logic bo, input logic [4:0] bw);
        return (ao && (aw == r)) || (bo && (bw == r));
    endfunction

    assign stall_o   = (age >= AGE_LIM) || (count >= CNT_HIGH);
    assign llu_ready = ready_en && (count < CNT_FULL);
    assign a_ok      = a_valid && !stall_o;
    assign b_ok      = b_valid && !stall_o;
    assign p1_free   = !(a_ok && b_ok);
    assign p2_free   = !a_ok && !b_ok;
    assign h0        = rd_ptr;
    assign h1        = rd_ptr + 1'b1;
    // A lane write this cycle already supersedes a matching queued result, so it pops without a port.
    assign kill0     = kill_q[h0] || lane_hit(wr_q[h0], a_ok, a_wr, b_ok, b_wr);
    assign kill1     = kill_q[h1] || lane_hit(wr_q[h1], a_ok, a_wr, b_ok, b_wr);
    assign push      = llu_valid && llu_ready && (llu_wr != '0) && !bypass;
    assign npop      = {1'b0, pop0} + {1'b0, pop1};

    always_comb begin
        Write   = 1'b0;
        WR      = '0;
        WD      = '0;
        Write2  = 1'b0;
        WR2     = '0;
        WD2     = '0;
        pop0    = 1'b0;
        pop1    = 1'b0;
        p1_used = 1'b0;
        bypass  = 1'b0;

        if (a_ok && b_ok) begin
            Write  = 1'b1;
            WR     = a_wr;
            WD     = a_wd;
            Write2 = 1'b1;
            WR2    = b_wr;
            WD2    = b_wd;
        end else if (a_ok) begin
            Write2 = 1'b1;
            WR2    = a_wr;
            WD2    = a_wd;
        end else if (b_ok) begin
            Write2 = 1'b1;
            WR2    = b_wr;
            WD2    = b_wd;
        end

`ifdef WBARB_BYPASS_EN
        if ((count == '0) && llu_valid && llu_ready && (llu_wr != '0) && p1_free) begin
            Write  = 1'b1;
            WR     = llu_wr;
            WD     = llu_wd;
            bypass = 1'b1;
        end
`endif

        if (count != '0) begin
            if (kill0) begin
                pop0 = 1'b1;
            end else if (p1_free) begin
                pop0    = 1'b1;
                p1_used = 1'b1;
                Write   = 1'b1;
                WR      = wr_q[h0];
                WD      = wd_q[h0];
            end
        end

        // Second entry only moves once the head has left; no reordering past a blocked head.
        if (pop0 && (count >= CNT_TWO)) begin
            if (kill1) begin
                pop1 = 1'b1;
            end else if (p1_free && !p1_used) begin
                pop1  = 1'b1;
                Write = 1'b1;
                WR    = wr_q[h1];
                WD    = wd_q[h1];
            end else if (p2_free) begin
                pop1   = 1'b1;
                Write2 = 1'b1;
                WR2    = wr_q[h1];
                WD2    = wd_q[h1];
            end
        end
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[PW'(i)] && !kill_q[PW'(i)]) busy_o[wr_q[PW'(i)]] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_q    <= '0;
            kill_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            age      <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld_q[PW'(i)] && lane_hit(wr_q[PW'(i)], a_ok, a_wr, b_ok, b_wr))
                    kill_q[PW'(i)] <= 1'b1;
            end
            if (pop0) vld_q[h0] <= 1'b0;
            if (pop1) vld_q[h1] <= 1'b0;
            if (push) begin
                vld_q[wr_ptr]  <= 1'b1;
                kill_q[wr_ptr] <= lane_hit(llu_wr, a_ok, a_wr, b_ok, b_wr);
                wr_ptr         <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + PW'(npop);
            count  <= count + CW'(push) - CW'(npop);
            if ((count == '0) || pop0) age <= '0;
            else if (age != AGE_MAX)   age <= age + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            wr_q[wr_ptr] <= llu_wr;
            wd_q[wr_ptr] <= llu_wd;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default build, DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, llu_valid = 1'b0;
    logic [4:0]  a_wr = '0, b_wr = '0, llu_wr = '0;
    logic [31:0] a_wd = '0, b_wd = '0, llu_wd = '0;
    logic        llu_ready, Write, Write2, stall_o;
    logic [4:0]  WR, WR2;
    logic [31:0] WD, WD2, busy_o;

    logic [31:0] rf [32];
    int tests_run = 0;
    int failures  = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .AGE_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .a_valid(a_valid), .a_wr(a_wr), .a_wd(a_wd),
        .b_valid(b_valid), .b_wr(b_wr), .b_wd(b_wd),
        .llu_valid(llu_valid), .llu_wr(llu_wr), .llu_wd(llu_wd), .llu_ready(llu_ready),
        .Write(Write), .WR(WR), .WD(WD),
        .Write2(Write2), .WR2(WR2), .WD2(WD2),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 Clk = ~Clk;

    // Register file model: port 2 is applied last so it wins on equal address.
    always @(posedge Clk) begin
        if (Write)  rf[WR]  <= WD;
        if (Write2) rf[WR2] <= WD2;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic lanes(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        a_valid = av; a_wr = ar; a_wd = ad;
        b_valid = bv; b_wr = br; b_wd = bd;
    endtask

    task automatic llu(input logic v, input logic [4:0] r, input logic [31:0] d);
        llu_valid = v; llu_wr = r; llu_wd = d;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        lanes(0, 0, 0, 0, 0, 0); llu(0, 0, 0);
        cyc(); cyc();
        tests_run++; if (Write !== 1'b0 || Write2 !== 1'b0) begin failures++; $display("FAIL rst_writes: got %b%b want 00", Write, Write2); end
        tests_run++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        tests_run++; if (busy_o !== 32'h0) begin failures++; $display("FAIL rst_busy: got %h want 0", busy_o); end
        tests_run++; if (llu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_high: got %b want 0", llu_ready); end
        Reset = 1'b0;
        #1;
        tests_run++; if (llu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_fall: got %b want 0", llu_ready); end
        cyc();
        tests_run++; if (llu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %b want 1", llu_ready); end
    endtask

    task automatic test_lanes();
        lanes(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        #1;
        tests_run++; if ({Write, WR, WD} !== {1'b1, 5'd3, 32'h11}) begin failures++; $display("FAIL lanes_p1: got %b/%0d/%h want 1/3/11", Write, WR, WD); end
        tests_run++; if ({Write2, WR2, WD2} !== {1'b1, 5'd3, 32'h22}) begin failures++; $display("FAIL lanes_p2: got %b/%0d/%h want 1/3/22", Write2, WR2, WD2); end
        cyc();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        tests_run++; if (rf[3] !== 32'h22) begin failures++; $display("FAIL lanes_r3: got %h want 22", rf[3]); end
    endtask

    task automatic test_drain();
        llu(1, 5'd5, 32'hAA);
        #1;
        tests_run++; if (llu_ready !== 1'b1 || Write !== 1'b0) begin failures++; $display("FAIL drain_accept: got ready=%b we=%b want 1/0", llu_ready, Write); end
        cyc();
        llu(0, 0, 0);
        #1;
        tests_run++; if ({Write, WR, WD, Write2} !== {1'b1, 5'd5, 32'hAA, 1'b0}) begin failures++; $display("FAIL drain_port1: got %b/%0d/%h/%b want 1/5/aa/0", Write, WR, WD, Write2); end
        tests_run++; if (busy_o !== 32'h20) begin failures++; $display("FAIL drain_busy_on: got %h want 00000020", busy_o); end
        cyc();
        tests_run++; if (busy_o !== 32'h0 || Write !== 1'b0) begin failures++; $display("FAIL drain_busy_off: got %h we=%b want 0/0", busy_o, Write); end
        tests_run++; if (rf[5] !== 32'hAA) begin failures++; $display("FAIL drain_r5: got %h want aa", rf[5]); end
        // Destination r0 is accepted and dropped.
        llu(1, 5'd0, 32'h55);
        #1;
        tests_run++; if (llu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %b want 1", llu_ready); end
        cyc();
        llu(0, 0, 0);
        #1;
        tests_run++; if (Write !== 1'b0 || busy_o !== 32'h0) begin failures++; $display("FAIL r0_discard: got we=%b busy=%h want 0/0", Write, busy_o); end
    endtask

    task automatic test_kill();
        lanes(1, 5'd1, 32'h1001, 1, 5'd2, 32'h1002);
        llu(1, 5'd7, 32'h77);
        cyc();
        llu(0, 0, 0);
        #1;
        tests_run++; if (busy_o !== 32'h80 || WR !== 5'd1) begin failures++; $display("FAIL kill_queued: got busy=%h wr=%0d want 00000080/1", busy_o, WR); end
        cyc();
        lanes(1, 5'd7, 32'h1, 0, 0, 0);
        #1;
        tests_run++; if ({Write, Write2, WR2, WD2} !== {1'b0, 1'b1, 5'd7, 32'h1}) begin failures++; $display("FAIL kill_ports: got %b/%b/%0d/%h want 0/1/7/1", Write, Write2, WR2, WD2); end
        cyc();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        tests_run++; if (busy_o !== 32'h0 || Write !== 1'b0) begin failures++; $display("FAIL kill_busy: got %h we=%b want 0/0", busy_o, Write); end
        cyc();
        tests_run++; if (rf[7] !== 32'h1) begin failures++; $display("FAIL kill_r7: got %h want 1", rf[7]); end
    endtask

    task automatic test_kill_same_cycle();
        lanes(1, 5'd9, 32'h99, 1, 5'd10, 32'hA0);
        llu(1, 5'd9, 32'hDEAD);
        cyc();
        lanes(0, 0, 0, 0, 0, 0); llu(0, 0, 0);
        #1;
        tests_run++; if (Write !== 1'b0 || busy_o !== 32'h0) begin failures++; $display("FAIL killsame_pop: got we=%b busy=%h want 0/0", Write, busy_o); end
        cyc(); cyc();
        tests_run++; if (rf[9] !== 32'h99) begin failures++; $display("FAIL killsame_r9: got %h want 99", rf[9]); end
    endtask

    task automatic test_one_lane();
        lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        llu(1, 5'd15, 32'h115);
        cyc();
        llu(1, 5'd16, 32'h116);
        #1;
        tests_run++; if ({Write, WR} !== {1'b1, 5'd1}) begin failures++; $display("FAIL onelane_lanefirst: got %b/%0d want 1/1", Write, WR); end
        cyc();
        llu(0, 0, 0);
        lanes(0, 0, 0, 1, 5'd4, 32'h44);
        #1;
        tests_run++; if ({Write, WR, WD} !== {1'b1, 5'd15, 32'h115}) begin failures++; $display("FAIL onelane_p1: got %b/%0d/%h want 1/15/115", Write, WR, WD); end
        tests_run++; if ({Write2, WR2, WD2} !== {1'b1, 5'd4, 32'h44}) begin failures++; $display("FAIL onelane_p2: got %b/%0d/%h want 1/4/44", Write2, WR2, WD2); end
        tests_run++; if (busy_o !== 32'h18000) begin failures++; $display("FAIL onelane_busy: got %h want 00018000", busy_o); end
        cyc();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        tests_run++; if ({Write, WR, WD, Write2} !== {1'b1, 5'd16, 32'h116, 1'b0}) begin failures++; $display("FAIL onelane_next: got %b/%0d/%h/%b want 1/16/116/0", Write, WR, WD, Write2); end
        cyc();
        tests_run++; if (busy_o !== 32'h0) begin failures++; $display("FAIL onelane_empty: got %h want 0", busy_o); end
    endtask

    task automatic test_starvation();
        int n;
        lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        llu(1, 5'd10, 32'h10A); cyc();
        llu(1, 5'd11, 32'h10B); cyc();
        llu(1, 5'd12, 32'h10C); cyc();
        llu(1, 5'd13, 32'h10D);
        #1;
        tests_run++; if (stall_o !== 1'b1 || llu_ready !== 1'b1) begin failures++; $display("FAIL starve_count3: got stall=%b ready=%b want 1/1", stall_o, llu_ready); end
        tests_run++; if ({Write, WR, WD, Write2, WR2, WD2} !== {1'b1, 5'd10, 32'h10A, 1'b1, 5'd11, 32'h10B}) begin
            failures++; $display("FAIL starve_drain2: got %b/%0d/%h %b/%0d/%h want 1/10/10a 1/11/10b", Write, WR, WD, Write2, WR2, WD2); end
        cyc();
        llu(0, 0, 0);
        #1;
        tests_run++; if (stall_o !== 1'b0 || WR !== 5'd1) begin failures++; $display("FAIL starve_release: got stall=%b wr=%0d want 0/1", stall_o, WR); end
        n = 0;
        while (stall_o === 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        tests_run++; if (n != 8) begin failures++; $display("FAIL starve_age: got %0d cycles want 8", n); end
        tests_run++; if ({Write, WR, Write2, WR2} !== {1'b1, 5'd12, 1'b1, 5'd13}) begin failures++; $display("FAIL starve_age_drain: got %b/%0d %b/%0d want 1/12 1/13", Write, WR, Write2, WR2); end
        cyc();
        tests_run++; if (stall_o !== 1'b0 || busy_o !== 32'h0 || WR !== 5'd1) begin failures++; $display("FAIL starve_done: got stall=%b busy=%h wr=%0d want 0/0/1", stall_o, busy_o, WR); end
        lanes(0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    task automatic test_reset_mid();
        lanes(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        llu(1, 5'd20, 32'h20); cyc();
        llu(1, 5'd21, 32'h21); cyc();
        llu(1, 5'd22, 32'h22); cyc();
        lanes(0, 0, 0, 0, 0, 0); llu(0, 0, 0);
        Reset = 1'b1;
        #1;
        tests_run++; if (busy_o !== 32'h0070_0000) begin failures++; $display("FAIL rmid_pre: got %h want 00700000", busy_o); end
        cyc();
        tests_run++; if ({Write, Write2, stall_o, llu_ready} !== 4'b0000 || busy_o !== 32'h0) begin
            failures++; $display("FAIL rmid_clear: got we=%b%b stall=%b ready=%b busy=%h want 0", Write, Write2, stall_o, llu_ready, busy_o); end
        Reset = 1'b0;
        #1;
        tests_run++; if (llu_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready_fall: got %b want 0", llu_ready); end
        cyc();
        tests_run++; if (llu_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", llu_ready); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (Write !== 1'b0 || Write2 !== 1'b0 || busy_o !== 32'h0) begin failures++; $display("FAIL rmid_quiet%0d: got we=%b%b busy=%h want 0", k, Write, Write2, busy_o); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_drain();
        test_kill();
        test_kill_same_cycle();
        test_one_lane();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
